// File: rtl/ifd3_rx.sv
// Three-line receiver: per-bit two-stage synchroniser, stability filter and
// an event/acknowledge register with a sticky overrun flag.
module ifd3_rx #(
    parameter int   FILT_LEN = 4,
    parameter logic INIT     = 1'b0
) (
    input  logic       CK,
    input  logic       RST_N,
    input  logic       D0,
    input  logic       D1,
    input  logic       D2,
    output logic       Q0,
    output logic       Q1,
    output logic       Q2,
    output logic [2:0] EVT,
    output logic       VALID,
    input  logic       ACK,
    output logic       OVR
);

    localparam logic [3:0] LIM = 4'(FILT_LEN - 1);

    logic [2:0] cap;
    logic [2:0] sync;
    logic [2:0] q;
    logic [2:0] upd;
    logic [3:0] cnt [3];
    logic       accept;

    always_ff @(posedge CK) begin
        if (!RST_N) begin
            cap  <= {3{INIT}};
            sync <= {3{INIT}};
        end else begin
            cap  <= {D2, D1, D0};
            sync <= cap;
        end
    end

    // A bit updates when its sync value has disagreed with Q for FILT_LEN edges.
    always_comb begin
        upd = '0;
        for (int i = 0; i < 3; i++) begin
            upd[i] = (sync[i] != q[i]) && (cnt[i] == LIM);
        end
    end

    always_ff @(posedge CK) begin
        if (!RST_N) begin
            q <= {3{INIT}};
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync[i] == q[i]) begin
                    cnt[i] <= 4'd0;
                end else if (upd[i]) begin
                    q[i]   <= sync[i];
                    cnt[i] <= 4'd0;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    // Handshake: VALID stays high until an edge with VALID && ACK; that edge
    // is the accept. ACK without VALID has no effect. Updates arriving on an
    // accept edge start a fresh event; updates while pending OR into EVT and
    // raise OVR.
    assign accept = VALID & ACK;

    always_ff @(posedge CK) begin
        if (!RST_N) begin
            VALID <= 1'b0;
            EVT   <= 3'b000;
            OVR   <= 1'b0;
        end else if (accept) begin
            VALID <= |upd;
            EVT   <= upd;
            OVR   <= 1'b0;
        end else if (|upd) begin
            VALID <= 1'b1;
            EVT   <= EVT | upd;
            if (VALID) begin
                OVR <= 1'b1;
            end
        end
    end

    assign Q0 = q[0];
    assign Q1 = q[1];
    assign Q2 = q[2];

endmodule
